posit_add_sched: RTL and testbench

- Shares one `posit_add` instance (N=16, es=2) among NREQ requesters, e.g. the FFT butterfly lanes.
- Arbitrates round-robin and forms subtraction by negating operand b.
- Tracks the single in-flight operation with a tag and buffers results in a small FIFO so consumers can apply backpressure.
- Supports a pause/drain handshake so the controller can quiesce the adder between FFT stages.

---
 rtl/posit_add_sched.sv | 229 ++++++++++++++++++++++
 tb/tb_posit_add_sched.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/posit_add_sched.sv
// posit_add_sched: round-robin front end that shares one posit_add (N=16, es=2)
// among NREQ requesters. Subtraction is formed by two's-complement negation of
// operand b. A single in-flight operation is tracked by tag; results land in a
// small FIFO so the consumer can backpressure. A pause/drain handshake lets the
// controller quiesce the adder between FFT stages.
// Optional build macro: POSIT_SCHED_STATS_EN enables the issue/stall counters;
// without it stat_ops_o/stat_stall_o are tied to zero.
module posit_add_sched #(
    parameter int N     = 16,
    parameter int NREQ  = 4,
    parameter int IDW   = 2,
    parameter int DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid_i,
    output logic [NREQ-1:0]      req_ready_o,
    input  logic [NREQ*N-1:0]    req_a_i,
    input  logic [NREQ*N-1:0]    req_b_i,
    input  logic [NREQ-1:0]      req_sub_i,
    output logic                 add_start_o,
    output logic [N-1:0]         add_in1_o,
    output logic [N-1:0]         add_in2_o,
    input  logic [N-1:0]         add_out_i,
    input  logic                 add_done_i,
    input  logic                 add_inf_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [N-1:0]         rsp_data_o,
    output logic [IDW-1:0]       rsp_id_o,
    output logic                 rsp_nar_o,
    input  logic                 pause_i,
    output logic                 pause_ack_o,
    output logic [15:0]          stat_ops_o,
    output logic [15:0]          stat_stall_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [IDW:0]  NREQ_L  = (IDW+1)'(NREQ);
    localparam logic [CW:0]   DEPTH_L = (CW+1)'(DEPTH);
    localparam logic [PW-1:0] LAST_L  = PW'(DEPTH - 1);

    typedef enum logic [1:0] {RUN, DRAIN, PAUSED} state_t;

    typedef struct packed {
        logic [N-1:0]   data;
        logic [IDW-1:0] id;
        logic           nar;
    } ent_t;

    // ---------------- per-lane operand preparation ----------------
    logic [NREQ-1:0][N-1:0] a_lane, b_lane;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_lane
            assign a_lane[gi] = req_a_i[gi*N +: N];
            // 0 - b modulo 2^N; NaR (only the sign bit set) maps onto itself.
            assign b_lane[gi] = req_sub_i[gi] ? (N'(0) - req_b_i[gi*N +: N])
                                              : req_b_i[gi*N +: N];
        end
    endgenerate

    // ---------------- state ----------------
    state_t         state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic           inflight_q;
    logic [IDW-1:0] tag_q;
    logic           nar_q;
    logic [N-1:0]   in1_q, in2_q;

    ent_t           mem_q [DEPTH];
    logic [PW-1:0]  wr_q, rd_q;
    logic [CW-1:0]  count_q, count_d;
    logic           rsp_valid_q;

    // ---------------- arbitration ----------------
    logic           found;
    logic [IDW-1:0] gnt_idx;
    logic [IDW:0]   arb_sum;
    logic [IDW-1:0] arb_idx;

    // Rotating priority search starting at ptr_q, wrapping at NREQ.
    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        arb_sum = '0;
        arb_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            arb_sum = {1'b0, ptr_q} + (IDW+1)'(k);
            if (arb_sum >= NREQ_L) arb_sum = arb_sum - NREQ_L;
            arb_idx = arb_sum[IDW-1:0];
            if (!found && req_valid_i[arb_idx]) begin
                found   = 1'b1;
                gnt_idx = arb_idx;
            end
        end
    end

    logic         pop, push, issue;
    logic [CW:0]  avail;

    assign pop   = rsp_valid_o & rsp_ready_i;
    assign push  = inflight_q;
    // Slots already committed: stored results plus the one in the adder,
    // minus the one leaving this cycle.
    assign avail = {1'b0, count_q} + (CW+1)'(inflight_q) - (CW+1)'(pop);
    // Pause wins over arbitration; reset forces all grants low.
    assign issue = found & (state_q == RUN) & ~pause_i & (avail < DEPTH_L) & ~rst;

    assign ptr_d       = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
    assign req_ready_o = issue ? (NREQ'(1) << gnt_idx) : '0;
    assign add_start_o = issue;
    assign add_in1_o   = issue ? a_lane[gnt_idx] : in1_q;
    assign add_in2_o   = issue ? b_lane[gnt_idx] : in2_q;

    // Issue bookkeeping: pointer, tag, NaR flag, held operands, in-flight bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q      <= '0;
            inflight_q <= 1'b0;
            tag_q      <= '0;
            nar_q      <= 1'b0;
            in1_q      <= '0;
            in2_q      <= '0;
        end else begin
            inflight_q <= issue;
            if (issue) begin
                ptr_q <= ptr_d;
                tag_q <= gnt_idx;
                nar_q <= add_inf_i;
                in1_q <= a_lane[gnt_idx];
                in2_q <= b_lane[gnt_idx];
            end
        end
    end

    // ---------------- result FIFO ----------------
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_L) ? '0 : p + PW'(1);
    endfunction

    assign count_d = count_q + CW'(push) - CW'(pop);

    // FIFO storage and pointers; the write side follows inflight_q only,
    // since the adder itself is never reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_q        <= '0;
            rd_q        <= '0;
            count_q     <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            if (push) begin
                mem_q[wr_q] <= '{data: add_out_i, id: tag_q, nar: nar_q};
                wr_q        <= ptr_inc(wr_q);
            end
            if (pop) rd_q <= ptr_inc(rd_q);
            count_q     <= count_d;
            rsp_valid_q <= (count_d != '0);
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = mem_q[rd_q].data;
    assign rsp_id_o    = mem_q[rd_q].id;
    assign rsp_nar_o   = mem_q[rd_q].nar;

    // ---------------- pause / drain FSM ----------------
    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= RUN;
        else     state_q <= state_d;
    end

    // Next state: drain the adder and FIFO before acknowledging the pause.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (pause_i) state_d = DRAIN;
            DRAIN:   if (!pause_i) state_d = RUN;
                     else if (!inflight_q && count_q == '0) state_d = PAUSED;
            PAUSED:  if (!pause_i) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    assign pause_ack_o = (state_q == PAUSED);

    // ---------------- statistics ----------------
`ifdef POSIT_SCHED_STATS_EN
    logic [15:0] ops_q, stall_q;

    // Saturating issue and stall counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ops_q   <= '0;
            stall_q <= '0;
        end else begin
            if (issue && ops_q != 16'hFFFF) ops_q <= ops_q + 16'd1;
            if (state_q == RUN && |req_valid_i && !issue && stall_q != 16'hFFFF)
                stall_q <= stall_q + 16'd1;
        end
    end

    assign stat_ops_o   = ops_q;
    assign stat_stall_o = stall_q;
`else
    assign stat_ops_o   = '0;
    assign stat_stall_o = '0;
`endif

    // ---------------- simulation check ----------------
`ifndef SYNTHESIS
    logic [1:0] post_rst_q;

    // Counts the first cycles after reset release, before add_done is trusted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                     post_rst_q <= '0;
        else if (post_rst_q != 2'd2) post_rst_q <= post_rst_q + 2'd1;
    end

    a_done_tracks: assert property (@(posedge clk) disable iff (rst)
        (post_rst_q == 2'd2) |-> (add_done_i == inflight_q));
`endif

endmodule

// File: tb/tb_posit_add_sched.sv
// Scoreboard bench for posit_add_sched with a stand-in one-cycle adder.
module tb_posit_add_sched;
    localparam int N = 16, NREQ = 4, IDW = 2, DEPTH = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [NREQ-1:0]   req_valid, req_ready, req_sub;
    logic [NREQ*N-1:0] req_a, req_b;
    logic              add_start, add_inf;
    logic [N-1:0]      add_in1, add_in2;
    logic [N-1:0]      add_out  = '0;
    logic              add_done = 1'b0;
    logic              rsp_valid, rsp_ready, rsp_nar;
    logic [N-1:0]      rsp_data;
    logic [IDW-1:0]    rsp_id;
    logic              pause, pause_ack;
    logic [15:0]       stat_ops, stat_stall;

    posit_add_sched #(.N(N), .NREQ(NREQ), .IDW(IDW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_a_i(req_a), .req_b_i(req_b), .req_sub_i(req_sub),
        .add_start_o(add_start), .add_in1_o(add_in1), .add_in2_o(add_in2),
        .add_out_i(add_out), .add_done_i(add_done), .add_inf_i(add_inf),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_data_o(rsp_data), .rsp_id_o(rsp_id), .rsp_nar_o(rsp_nar),
        .pause_i(pause), .pause_ack_o(pause_ack),
        .stat_ops_o(stat_ops), .stat_stall_o(stat_stall)
    );

    // Stand-in adder: exact posit sums for the directed vectors, NaR
    // propagation, and an arbitrary deterministic mix for everything else.
    function automatic logic [15:0] padd(input logic [15:0] x, input logic [15:0] y);
        if (x == 16'h8000 || y == 16'h8000) return 16'h8000;
        if (x == 16'h4000 && y == 16'h4800) return 16'h4C00;
        if (x == 16'h4C00 && y == 16'hC000) return 16'h4800;
        return (x + y) ^ 16'h00A5;
    endfunction

    assign add_inf = (add_in1 == 16'h8000) || (add_in2 == 16'h8000);
    always @(posedge clk) begin
        add_done <= add_start;
        if (add_start) add_out <= padd(add_in1, add_in2);
    end

    typedef struct packed {
        logic [15:0]    data;
        logic [IDW-1:0] id;
        logic           nar;
    } exp_t;

    exp_t exp_q[$];
    int   grant_log[$];
    int   rsp_log[$];
    int   vectors = 0, miscompares = 0;
    int   n_issue = 0, n_rsp = 0, cyc = 0, issue_cyc = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: push expectations on accept, pop and compare on delivery.
    logic [15:0]    ma, mb;
    exp_t           me;
    logic           hold_v = 1'b0;
    logic [15:0]    hold_data, last_data;
    logic [IDW-1:0] hold_id;
    logic           hold_nar, last_nar;

    always @(negedge clk) begin
        if (rst) begin
            hold_v = 1'b0;
        end else begin
            chk("onehot_ready", 32'($onehot0(req_ready)), 1);
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    ma = req_a[i*N +: N];
                    mb = req_sub[i] ? 16'(16'h0000 - req_b[i*N +: N]) : req_b[i*N +: N];
                    chk("start", 32'(add_start), 1);
                    chk("in1", 32'(add_in1), 32'(ma));
                    chk("in2", 32'(add_in2), 32'(mb));
                    me.data = padd(ma, mb);
                    me.id   = IDW'(i);
                    me.nar  = (ma == 16'h8000) || (mb == 16'h8000);
                    exp_q.push_back(me);
                    grant_log.push_back(i);
                    n_issue++;
                    issue_cyc = cyc;
                end
            end
            if (hold_v) begin
                chk("hold_valid", 32'(rsp_valid), 1);
                chk("hold_data", 32'(rsp_data), 32'(hold_data));
                chk("hold_id", 32'(rsp_id), 32'(hold_id));
                chk("hold_nar", 32'(rsp_nar), 32'(hold_nar));
            end
            if (rsp_valid && rsp_ready) begin
                chk("sb_nonempty", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    me = exp_q.pop_front();
                    chk("rsp_data", 32'(rsp_data), 32'(me.data));
                    chk("rsp_id", 32'(rsp_id), 32'(me.id));
                    chk("rsp_nar", 32'(rsp_nar), 32'(me.nar));
                end
                rsp_log.push_back(int'(rsp_id));
                last_data = rsp_data;
                last_nar  = rsp_nar;
                n_rsp++;
            end
            hold_v    = rsp_valid && !rsp_ready;
            hold_data = rsp_data;
            hold_id   = rsp_id;
            hold_nar  = rsp_nar;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b, input logic s);
        req_a[i*N +: N] = a;
        req_b[i*N +: N] = b;
        req_sub[i]      = s;
        req_valid[i]    = 1'b1;
    endtask

    task automatic wait_rsp(input int budget);
        int k = 0;
        while (!rsp_valid && k < budget) begin tick(); k++; end
        chk("rsp_timeout", 32'(rsp_valid), 1);
    endtask

    task automatic wait_drain(input int budget);
        int k = 0;
        while (exp_q.size() != 0 && k < budget) begin tick(); k++; end
        chk("drain", 32'(exp_q.size()), 0);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_ready"}, 32'(req_ready), 0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
        chk({tag, "_start"}, 32'(add_start), 0);
        chk({tag, "_in1"}, 32'(add_in1), 0);
        chk({tag, "_in2"}, 32'(add_in2), 0);
        chk({tag, "_rsp_data"}, 32'(rsp_data), 0);
        chk({tag, "_ack"}, 32'(pause_ack), 0);
        chk({tag, "_ops"}, 32'(stat_ops), 0);
        chk({tag, "_stall"}, 32'(stat_stall), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete");
        $fatal(1);
    end

    initial begin
        int base, k;
        logic [15:0] stall0;
        req_valid = '0; req_a = '0; req_b = '0; req_sub = '0;
        rsp_ready = 1'b1; pause = 1'b0; rst = 1'b1;

        // Reset: requests asserted but nothing may be granted.
        repeat (3) @(posedge clk);
        #1;
        req_valid = '1;
        #1;
        chk_quiet("reset");
        req_valid = '0;
        rst = 1'b0;
        tick(); tick();

        // Single add, latency 2 from accept.
        set_req(0, 16'h4000, 16'h4800, 1'b0);
        tick();
        req_valid = '0;
        wait_rsp(10);
        chk("add_latency", 32'(cyc - issue_cyc), 2);
        chk("add_data", 32'(rsp_data), 32'h4C00);
        chk("add_id", 32'(rsp_id), 0);
        chk("add_nar", 32'(rsp_nar), 0);
        wait_drain(10);

        // Subtract on requester 2.
        set_req(2, 16'h4C00, 16'h4000, 1'b1);
        #1;
        chk("sub_ready", 32'(req_ready), 32'b0100);
        chk("sub_in2", 32'(add_in2), 32'hC000);
        tick();
        req_valid = '0;
        wait_rsp(10);
        chk("sub_data", 32'(rsp_data), 32'h4800);
        chk("sub_id", 32'(rsp_id), 2);
        wait_drain(10);

        // Requester 3 alone, leaving the pointer at 0.
        set_req(3, 16'h1111, 16'h2222, 1'b0);
        #1;
        chk("r3_ready", 32'(req_ready), 32'b1000);
        tick();
        req_valid = '0;
        wait_drain(10);

        // Fairness: all four valid for 8 cycles.
        grant_log.delete(); rsp_log.delete();
        for (int i = 0; i < NREQ; i++)
            set_req(i, 16'(16'h1000 + i * 16'h0111), 16'(16'h0300 + i), 1'(i % 2));
        repeat (8) tick();
        req_valid = '0;
        chk("fair_count", 32'(grant_log.size()), 8);
        for (int i = 0; i < 8 && i < grant_log.size(); i++)
            chk("fair_order", 32'(grant_log[i]), 32'(i % 4));
        wait_drain(20);
        chk("fair_rsp_count", 32'(rsp_log.size()), 8);
        for (int i = 0; i < 8 && i < rsp_log.size(); i++)
            chk("fair_rsp_order", 32'(rsp_log[i]), 32'(i % 4));

        // Backpressure: FIFO plus in-flight slot fill after two issues.
        base = n_issue;
        stall0 = stat_stall;
        rsp_ready = 1'b0;
        set_req(0, 16'h2345, 16'h0101, 1'b0);
        set_req(1, 16'h3456, 16'h0202, 1'b1);
        repeat (6) tick();
        chk("bp_issues", 32'(n_issue - base), 2);
        chk("bp_ready", 32'(req_ready), 0);
        chk("bp_rsp_valid", 32'(rsp_valid), 1);
`ifdef POSIT_SCHED_STATS_EN
        chk("bp_stall", 32'(stat_stall - stall0), 4);
        chk("bp_ops", 32'(stat_ops), 32'(n_issue));
`else
        chk("bp_stall_tied", 32'(stat_stall), 32'(stall0));
        chk("bp_ops_tied", 32'(stat_ops), 0);
`endif
        rsp_ready = 1'b1;
        repeat (4) tick();
        req_valid = '0;
        wait_drain(20);
        chk("bp_balance", 32'(n_rsp), 32'(n_issue));

        // NaR operand, then pause the cycle after the issue.
        base = n_issue;
        set_req(1, 16'h8000, 16'h4000, 1'b0);
        tick();
        req_valid = '0;
        set_req(0, 16'h0AAA, 16'h0555, 1'b0);
        set_req(3, 16'h0BBB, 16'h0444, 1'b1);
        pause = 1'b1;
        #1;
        chk("pause_ready", 32'(req_ready), 0);
        k = 0;
        while (!pause_ack && k < 12) begin tick(); k++; end
        chk("pause_ack", 32'(pause_ack), 1);
        chk("pause_issues", 32'(n_issue - base), 1);
        chk("pause_sb_empty", 32'(exp_q.size()), 0);
        chk("nar_data", 32'(last_data), 32'h8000);
        chk("nar_flag", 32'(last_nar), 1);
        tick(); tick();
        chk("paused_hold", 32'(pause_ack), 1);
        chk("paused_issues", 32'(n_issue - base), 1);
        pause = 1'b0;
        k = 0;
        while (n_issue == base + 1 && k < 10) begin tick(); k++; end
        req_valid = '0;
        chk("resume_issue", 32'(n_issue - base), 2);
        chk("resume_gnt", 32'(grant_log[$]), 3);
        chk("resume_ack_low", 32'(pause_ack), 0);
        wait_drain(10);

        // Reset while an operation is in flight.
        set_req(2, 16'h1234, 16'h0111, 1'b0);
        tick();
        req_valid = '0;
        rst = 1'b1;
        exp_q.delete();
        #1;
        chk_quiet("midrst");
        tick(); tick();
        rst = 1'b0;
        repeat (4) begin
            tick();
            chk("midrst_no_rsp", 32'(rsp_valid), 0);
        end
        set_req(1, 16'h0C0C, 16'h0303, 1'b0);
        set_req(3, 16'h0D0D, 16'h0404, 1'b1);
        #1;
        chk("midrst_first_gnt", 32'(req_ready), 32'b0010);
        tick();
        req_valid = '0;
        wait_drain(10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
